// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and address helpers for the data memory responder
package cpu_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic logic [63:0] word_index(input logic [63:0] addr);
      return addr >> 2;
   endfunction

   // Misaligned byte address or word index past the end of the array
   function automatic logic addr_error(input logic [63:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
   endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with one sync write port, one comb read port, debug taps
module mem_array #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata,
   output logic [WIDTH-1:0] o_word0,
   output logic [WIDTH-1:0] o_word1
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
   assign o_word0 = r_mem[0];
   assign o_word1 = r_mem[1];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - valid/ready load/store responder with wait-state latency
module data_mem_responder
   import cpu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] out_reg0,
   output logic [WIDTH-1:0] out_reg1
);

   localparam int AW = $clog2(DEPTH);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic             r_we;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;

   logic             w_accept;
   logic             w_done;
   logic             w_err;
   logic [AW-1:0]    w_idx;
   logic             w_mem_we;
   logic [WIDTH-1:0] w_mem_rdata;

   assign w_accept = req_valid && req_ready;
   assign w_done   = (r_state == WAIT) && (r_cnt == 4'd0);
   assign w_err    = addr_error(64'(r_addr), DEPTH);
   assign w_idx    = AW'(word_index(64'(r_addr)));
   // The edge leaving WAIT is the single commit point for stores
   assign w_mem_we = w_done && r_we && !w_err;

   mem_array #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_mem_we),
      .i_waddr (w_idx),
      .i_wdata (r_wdata),
      .i_raddr (w_idx),
      .o_rdata (w_mem_rdata),
      .o_word0 (out_reg0),
      .o_word1 (out_reg1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = rst;
            if (req_valid) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY);
         end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_done) begin
            r_err   <= w_err;
            r_rdata <= w_err ? '0 : (r_we ? r_wdata : w_mem_rdata);
         end else if ((r_state == RESP) && resp_ready) begin
            r_err <= 1'b0;
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;

   typedef struct {
      int          inst;
      logic [31:0] rdata;
      bit          err;
      int          edge_c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];
   logic [31:0] out_reg0   [2];
   logic [31:0] out_reg1   [2];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rr_mode  = 0;
   int          lat [2]  = '{2, 0};
   logic [31:0] mm [2][16];
   exp_t        sb[$];
   bit          prev_v [2] = '{0, 0};

   for (genvar g = 0; g < 2; g++) begin : g_dut
      data_mem_responder #(
         .WIDTH  (32),
         .DEPTH  (16),
         .LATENCY(g == 0 ? 2 : 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g]),
         .out_reg0   (out_reg0[g]),
         .out_reg1   (out_reg1[g])
      );
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         case (rr_mode)
            0:       resp_ready[g] = 1'b1;
            1:       resp_ready[g] = 1'($urandom_range(0, 1));
            default: resp_ready[g] = 1'b0;
         endcase
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input int g, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rd, output bit err);
      err = (addr % 4 != 0) || (addr / 4 >= 16);
      if (err) begin
         rd = 32'h0;
      end else if (we) begin
         mm[g][addr / 4] = wdata;
         rd = wdata;
      end else begin
         rd = mm[g][addr / 4];
      end
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       return 32'($urandom_range(0, 15) * 4);
      else if (r == 7) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) return 32'($urandom_range(16, 1000) * 4);
      else             return 32'($urandom);
   endfunction

   // Monitor: compares every presented response against the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         prev_v[0] = 1'b0;
         prev_v[1] = 1'b0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            if (resp_valid[g]) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_resp: inst %0d rdata %0h with no expected response", g, resp_rdata[g]);
               end else begin
                  if (!prev_v[g]) check("resp_latency_edge", 64'(cyc), 64'(sb[0].edge_c));
                  check("resp_inst", 64'(g), 64'(sb[0].inst));
                  check("resp_rdata", 64'(resp_rdata[g]), 64'(sb[0].rdata));
                  check("resp_err", 64'(resp_err[g]), 64'(sb[0].err));
                  check("req_ready_in_resp", 64'(req_ready[g]), 64'(0));
                  if (resp_ready[g]) void'(sb.pop_front());
               end
            end
            prev_v[g] = resp_valid[g];
         end
      end
   end

   task automatic issue(input int g, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, input bit expect_resp, output int acc);
      int          t;
      exp_t        e;
      logic [31:0] rd;
      bit          er;
      req_valid[g] = 1'b1;
      req_we[g]    = we;
      req_addr[g]  = addr;
      req_wdata[g] = wdata;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ready[g] && t < 100);
      if (!req_ready[g]) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: inst %0d req_ready stayed 0 for %0d cycles", g, t);
         req_valid[g] = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (expect_resp) begin
         model(g, we, addr, wdata, rd, er);
         e.inst   = g;
         e.rdata  = rd;
         e.err    = er;
         e.edge_c = acc + 1 + lat[g];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid[g] = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      check("drain_scoreboard_empty", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic check_taps(input string name);
      for (int g = 0; g < 2; g++) begin
         check({name, "_out_reg0"}, 64'(out_reg0[g]), 64'(mm[g][0]));
         check({name, "_out_reg1"}, 64'(out_reg1[g]), 64'(mm[g][1]));
      end
   endtask

   initial begin
      int acc;
      int a [4];
      bit seen;
      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         req_we[g]    = 1'b0;
         req_addr[g]  = 32'h0;
         req_wdata[g] = 32'h0;
         for (int i = 0; i < 16; i++) mm[g][i] = 32'h0;
      end

      @(posedge clk);
      #1;
      check("req_ready_in_reset", 64'(req_ready[0]), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready[0]), 64'(1));
      check("reset_resp_valid", 64'(resp_valid[0]), 64'(0));
      check("reset_resp_rdata", 64'(resp_rdata[0]), 64'(0));
      check_taps("reset");
      @(posedge clk);
      #1;

      issue(0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1, acc);
      drain();
      check("store_out_reg1", 64'(out_reg1[0]), 64'hDEADBEEF);
      issue(0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, acc);
      drain();

      rr_mode = 2;
      issue(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      for (int t = 0; t < 20 && !resp_valid[0]; t++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check("backpressure_resp_valid_held", 64'(resp_valid[0]), 64'(1));
      rr_mode = 0;
      drain();

      issue(0, 1'b1, 32'h2, 32'hBAD0BAD0, 1'b0, 1'b1, acc);
      issue(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, acc);
      drain();
      check_taps("after_errors");

      issue(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      drain();
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b1, 32'(i * 4), $urandom, (i < 3), 1'b1, a[i]);
      end
      for (int i = 1; i < 4; i++) check("lat0_accept_spacing", 64'(a[i] - a[i-1]), 64'(3));
      drain();
      check_taps("throughput");

      rr_mode = 1;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 40; i++) begin
            issue(g, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 1'b1, acc);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
         end
         drain();
      end
      rr_mode = 0;
      drain();
      check_taps("random");

      issue(0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0, acc);
      rst = 1'b0;
      #1;
      check("req_ready_mid_reset", 64'(req_ready[0]), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) for (int i = 0; i < 16; i++) mm[g][i] = 32'h0;
      seen = 1'b0;
      @(negedge clk);
      check("after_reset_req_ready", 64'(req_ready[0]), 64'(1));
      check("after_reset_out_reg0", 64'(out_reg0[0]), 64'(0));
      for (int t = 0; t < 10; t++) begin
         if (resp_valid[0]) seen = 1'b1;
         @(negedge clk);
      end
      check("no_resp_after_reset", 64'(seen), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
